mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline stage 4 (ME) of the 5-stage MIPS CPU.
- Consumes the EX->ME register outputs and drives the data-memory bus through a req/ready handshake.
- Generates the stall that freezes upstream registers while memory is slow.
- Registers its results into the ME->WB boundary consumed by write-back.
- Includes a bounded-wait timeout that completes a hung access and raises a sticky error.

Parameters:
DATA_W, 32, width of address, ALU result and data buses
MAX_WAIT, 15, wait-state cycles tolerated before timeout (>=1)

Ports:
clock  in  1  system clock, all state on rising edge
reset_0  in  1  reset; synchronous, active-low, sampled on posedge clock
ans_me  in  DATA_W  ALU result / effective address from EX->ME register
b_me  in  DATA_W  store data from EX->ME register
rw_me  in  5  destination register number
wreg_me  in  1  instruction writes register file
wmem_me  in  1  store instruction
rmem_me  in  1  load instruction
dm_req  out  1  memory request (combinational)
dm_we  out  1  1=write, 0=read
dm_addr  out  DATA_W  equals ans_me
dm_wdata  out  DATA_W  equals b_me
dm_rdata  in  DATA_W  read data, valid when dm_ready=1
dm_ready  in  1  memory completes current request this cycle
stall  out  1  1 = hold PC, IF/ID, ID/EX, EX/ME (drive their enable low)
ans_wb  out  DATA_W  registered ALU result
mdata_wb  out  DATA_W  registered load data
rw_wb  out  5  registered destination register
wreg_wb  out  1  registered write-enable
m2reg_wb  out  1  1 = WB selects mdata_wb
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: when reset_0=0 at a rising edge, state<=IDLE, wait_cnt<=0, and all *_wb outputs and bus_err <=0. While reset_0=0, dm_req and stall are forced to 0 combinationally. Reset mid-WAIT abandons the access with no WB write.
- access = rmem_me | wmem_me. If both are set, the store wins: dm_we=1 and m2reg_wb=0.
- FSM states:
  - IDLE: dm_req = access. If access & !dm_ready, go to WAIT with wait_cnt<=0.
  - WAIT: dm_req=1. If done, go to IDLE; else wait_cnt<=wait_cnt+1.
- done = dm_req & (dm_ready | timeout). timeout = (state==WAIT) & (wait_cnt==MAX_WAIT) & !dm_ready.
- stall = dm_req & !done (combinational). Because upstream inputs are held while stall=1, dm_addr, dm_wdata and dm_we are stable for the whole request.
- WB register update each edge (reset_0=1):
  - If stall: insert a bubble: wreg_wb<=0, m2reg_wb<=0. Other WB fields may hold.
  - Else: ans_wb<=ans_me, rw_wb<=rw_me, wreg_wb<=wreg_me, m2reg_wb<=rmem_me&!wmem_me.
  - mdata_wb<=dm_rdata if the load completed with dm_ready; <=0 if it completed by timeout or the instruction is not a load.
- Latency:
  - Zero-wait access (dm_ready in the IDLE cycle): no stall; result visible one cycle later.
  - ready after k WAIT cycles: stall high k+1 cycles.
  - Timeout: stall high MAX_WAIT+1 cycles, then completes.
- bus_err <=1 on the edge ending a timeout cycle. It stays 1 until reset.
- Non-memory instructions pass straight through with dm_req=0. Back-to-back accesses need no idle cycle: IDLE is re-entered and the next access is evaluated the same cycle it arrives.
- wait_cnt width is clog2(MAX_WAIT+1) and it does not wrap; it is bounded by the timeout.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and REG_W=5 constants
  - mem_state_t enum {IDLE, WAIT}
  - bubble constants for the WB control fields.
- One natural sub-module, reg_mewb: the ME->WB pipeline register with its synchronous active-low reset, enable, and bubble-insert input. mem_stage holds the FSM, counter, stall and bus glue.

Test Plan:
- ALU op (wreg_me=1, ans_me=0x0000_1234, rw_me=5, no access) -> dm_req=0, stall=0; next edge: ans_wb=0x1234, rw_wb=5, wreg_wb=1, m2reg_wb=0.
- Load with dm_ready=1 same cycle, dm_rdata=0xDEAD_BEEF, ans_me=0x40 -> dm_addr=0x40, dm_we=0, stall=0; next edge: mdata_wb=0xDEADBEEF, m2reg_wb=1.
- Store, dm_ready delayed 3 cycles after request -> stall=1 for 3 cycles with wreg_wb=0 bubbles; dm_we=1 and dm_wdata=b_me held constant; stall drops in the ready cycle.
- Load, dm_ready never asserted, MAX_WAIT=15 -> stall=1 for exactly 16 cycles, then 0; next edge: bus_err=1, mdata_wb=0; bus_err stays 1 afterwards.
- reset_0=0 during WAIT cycle 4 -> dm_req and stall go 0 immediately; next edge: all WB outputs 0, state IDLE. After release, a zero-wait load completes normally.
- rmem_me=wmem_me=1 -> dm_we=1 and m2reg_wb=0 after completion.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 5-stage MIPS pipeline.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Values written into the WB control fields when a bubble is inserted
  localparam logic WREG_BUBBLE  = 1'b0;
  localparam logic M2REG_BUBBLE = 1'b0;

endpackage

// File: rtl/mem_stage_reg_mewb.sv
// ME->WB pipeline register: sync active-low reset, load enable, bubble insert.
module reg_mewb #(
  parameter int DW = 32
) (
  input  logic                     clock,
  input  logic                     reset_0,
  input  logic                     en,
  input  logic                     bubble,
  input  logic [DW-1:0]            ans_me,
  input  logic [DW-1:0]            mdata_me,
  input  logic [cpu_pkg::REG_W-1:0] rw_me,
  input  logic                     wreg_me,
  input  logic                     m2reg_me,
  output logic [DW-1:0]            ans_wb,
  output logic [DW-1:0]            mdata_wb,
  output logic [cpu_pkg::REG_W-1:0] rw_wb,
  output logic                     wreg_wb,
  output logic                     m2reg_wb
);
  import cpu_pkg::*;

  always_ff @(posedge clock) begin
    if (!reset_0) begin
      ans_wb   <= '0;
      mdata_wb <= '0;
      rw_wb    <= '0;
      wreg_wb  <= 1'b0;
      m2reg_wb <= 1'b0;
    end else begin
      // A bubble only kills the control fields; data fields simply hold
      if (bubble) begin
        wreg_wb  <= WREG_BUBBLE;
        m2reg_wb <= M2REG_BUBBLE;
      end else if (en) begin
        wreg_wb  <= wreg_me;
        m2reg_wb <= m2reg_me;
      end
      if (en && !bubble) begin
        ans_wb   <= ans_me;
        mdata_wb <= mdata_me;
        rw_wb    <= rw_me;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS ME stage: data-memory handshake FSM, stall generation, bounded-wait
// timeout with sticky bus error, and the ME->WB register.
module mem_stage #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic                      clock,
  input  logic                      reset_0,
  input  logic [DATA_W-1:0]         ans_me,
  input  logic [DATA_W-1:0]         b_me,
  input  logic [cpu_pkg::REG_W-1:0] rw_me,
  input  logic                      wreg_me,
  input  logic                      wmem_me,
  input  logic                      rmem_me,
  output logic                      dm_req,
  output logic                      dm_we,
  output logic [DATA_W-1:0]         dm_addr,
  output logic [DATA_W-1:0]         dm_wdata,
  input  logic [DATA_W-1:0]         dm_rdata,
  input  logic                      dm_ready,
  output logic                      stall,
  output logic [DATA_W-1:0]         ans_wb,
  output logic [DATA_W-1:0]         mdata_wb,
  output logic [cpu_pkg::REG_W-1:0] rw_wb,
  output logic                      wreg_wb,
  output logic                      m2reg_wb,
  output logic                      bus_err
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  mem_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              bus_err_reg;

  logic              access;
  logic              is_load;
  logic              timeout;
  logic              done;
  logic [DATA_W-1:0] mdata_me;

  assign access  = rmem_me | wmem_me;
  // Store has priority when both load and store are flagged
  assign is_load = rmem_me & ~wmem_me;

  assign dm_req   = reset_0 & ((state_reg == WAIT) | access);
  assign dm_we    = wmem_me;
  assign dm_addr  = ans_me;
  assign dm_wdata = b_me;

  assign timeout = (state_reg == WAIT) & (wait_cnt_reg == CNT_MAX) & ~dm_ready;
  assign done    = dm_req & (dm_ready | timeout);
  assign stall   = dm_req & ~done;

  assign mdata_me = (is_load & dm_ready) ? dm_rdata : '0;
  assign bus_err  = bus_err_reg;

  always_ff @(posedge clock) begin
    if (!reset_0) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (timeout)
        bus_err_reg <= 1'b1;
    end
  end

  // Counter cannot pass CNT_MAX: that cycle always completes (ready or timeout)
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (access && !dm_ready) begin
          state_next    = WAIT;
          wait_cnt_next = '0;
        end
      end
      WAIT: begin
        if (done)
          state_next = IDLE;
        else
          wait_cnt_next = wait_cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  reg_mewb #(
    .DW(DATA_W)
  ) u_reg_mewb (
    .clock    (clock),
    .reset_0  (reset_0),
    .en       (~stall),
    .bubble   (stall),
    .ans_me   (ans_me),
    .mdata_me (mdata_me),
    .rw_me    (rw_me),
    .wreg_me  (wreg_me),
    .m2reg_me (is_load),
    .ans_wb   (ans_wb),
    .mdata_wb (mdata_wb),
    .rw_wb    (rw_wb),
    .wreg_wb  (wreg_wb),
    .m2reg_wb (m2reg_wb)
  );

endmodule
